// File: rtl/acc_sequencer_if.sv
// Datapath-facing bus of the accumulator sequencer: instruction ROM fetch,
// ALU opcode/carry-in/flags, and the three write enables.
interface acc_sequencer_if #(
   parameter int PC_W = 8
);
   logic [PC_W-1:0] instr_addr;
   logic [8:0]      instr_in;
   logic [3:0]      alu_op;
   logic            alu_ci;
   logic [4:0]      operand_sel;
   logic            alu_co;
   logic            alu_z;
   logic            alu_neg;
   logic            acc_we;
   logic            reg_we;
   logic            mem_we;

   modport master (
      output instr_addr, alu_op, alu_ci, operand_sel, acc_we, reg_we, mem_we,
      input  instr_in, alu_co, alu_z, alu_neg
   );

   modport slave (
      input  instr_addr, alu_op, alu_ci, operand_sel, acc_we, reg_we, mem_we,
      output instr_in, alu_co, alu_z, alu_neg
   );
endinterface

// File: rtl/acc_sequencer.sv
// Two-cycle (FETCH/EXEC) control sequencer for the accumulator CPU: issues
// opcodes, gates write enables, latches {c,z,n} flags and resolves branches.
package acc_defs_pkg;
   typedef enum logic [3:0] {
      kCLR = 4'h0, kADD = 4'h1, kSUB = 4'h2, kLDR = 4'h3,
      kSTR = 4'h4, kAND = 4'h5, kXOR = 4'h6, kMLD = 4'h7,
      kMST = 4'h8, kLDI = 4'h9, kSHL = 4'hA, kSHR = 4'hB,
      kNOT = 4'hC, kJMP = 4'hD, kBRN = 4'hE, kBRZ = 4'hF
   } op_mne_e;
endpackage

module acc_sequencer
   import acc_defs_pkg::*;
#(
   parameter int PC_W     = 8,
   parameter int PROG_LEN = 255,
   parameter int CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   acc_sequencer_if.master       bus,
   output logic [2:0]            flags,
   output logic [CNT_W-1:0]      retired,
   output logic                  done
);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_e;

   state_e            state, state_nxt;
   logic [PC_W-1:0]   pc, pc_nxt;
   logic [8:0]        ir, ir_nxt;
   logic [2:0]        flags_nxt;
   logic [CNT_W-1:0]  retired_nxt;
   logic              done_nxt;

   op_mne_e           op;
   logic              taken;
   logic [PC_W-1:0]   target;
   logic [PC_W:0]     pc_inc_ext;
   logic              last_instr;

   assign op          = op_mne_e'(ir[8:5]);
   assign pc_inc_ext  = {1'b0, pc} + (PC_W+1)'(1);
   // Compare one bit wider so a PROG_LEN of 2^PC_W is still reachable.
   assign last_instr  = (pc_inc_ext == (PC_W+1)'(PROG_LEN));

   assign bus.instr_addr  = pc;
   assign bus.alu_ci      = flags[2];
   assign bus.operand_sel = ir[4:0];

   // NOTE: sequential state uses non-blocking assignments only; the reset is
   // synchronous, so it lives inside the clocked branch rather than the sensitivity list.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         pc      <= '0;
         ir      <= '0;
         flags   <= '0;
         retired <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         ir      <= ir_nxt;
         flags   <= flags_nxt;
         retired <= retired_nxt;
         done    <= done_nxt;
      end
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      ir_nxt      = ir;
      flags_nxt   = flags;
      retired_nxt = retired;
      done_nxt    = done;
      bus.alu_op  = kCLR;
      bus.acc_we  = 1'b0;
      bus.reg_we  = 1'b0;
      bus.mem_we  = 1'b0;
      taken       = 1'b0;
      target      = pc + {{(PC_W-5){ir[4]}}, ir[4:0]};

      unique case (state)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_nxt   = S_FETCH;
               pc_nxt      = '0;
               flags_nxt   = '0;
               retired_nxt = '0;
               done_nxt    = 1'b0;
            end
         end

         S_FETCH: begin
            ir_nxt    = bus.instr_in;
            state_nxt = S_EXEC;
         end

         S_EXEC: begin
            bus.alu_op = ir[8:5];
            case (op)
               kADD, kSUB, kSHL: begin
                  bus.acc_we = 1'b1;
                  flags_nxt  = {bus.alu_co, bus.alu_z, bus.alu_neg};
               end
               kLDR, kAND, kXOR, kMLD, kLDI, kSHR, kNOT: begin
                  bus.acc_we = 1'b1;
                  flags_nxt  = {flags[2], bus.alu_z, bus.alu_neg};
               end
               kSTR: bus.reg_we = 1'b1;
               kMST: bus.mem_we = 1'b1;
               kJMP: begin
                  taken  = 1'b1;
                  target = {{(PC_W-5){1'b0}}, ir[4:0]};
               end
               // BRN looks at the latched n flag, BRZ at the live ALU zero.
               kBRN: taken = flags[0];
               kBRZ: taken = bus.alu_z;
               default: flags_nxt = '0;
            endcase

            retired_nxt = (&retired) ? retired : retired + CNT_W'(1);
            pc_nxt      = taken ? target : pc_inc_ext[PC_W-1:0];

            if (!taken && last_instr) begin
               state_nxt = S_DONE;
               done_nxt  = 1'b1;
            end else begin
               state_nxt = S_FETCH;
            end
         end

         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
